bcd_serial_subtractor: RTL and testbench

- Digit-serial multi-digit BCD subtractor: computes Minuend − Subtrahend − Borrow_in over DIGITS packed BCD digits.
- Processes one digit per clock, least-significant digit first, using a single per-digit borrow/+10 correction stage.
- Complements the team's combinational BCD add path. It is the subtract side of the decimal arithmetic datapath, with a Start/Done handshake for a sequencing controller.

---
 rtl/bcd_serial_subtractor.sv | 161 ++++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_subtractor.sv
// ---------------------------------------------------------------------------
// bcd_serial_subtractor
//
// Digit-serial packed-BCD subtractor: difference = minuend - subtrahend -
// borrow_in, one BCD digit per clock, least-significant digit first.
// An underflow wraps in ten's complement, and the final borrow is reported.
//
// Ports
//   clock_i       rising-edge clock
//   reset_i       asynchronous, active-high reset
//   start_i       request; accepted only in IDLE or DONE
//   minuend_i     packed BCD operand, digit 0 in bits [3:0]
//   subtrahend_i  packed BCD operand, same packing
//   borrow_in_i   initial borrow into digit 0
//   difference_o  registered BCD result, held until the next completion
//   borrow_out_o  final borrow (minuend < subtrahend + borrow_in)
//   invalid_o     a latched operand digit was > 9 (result forced to 0)
//   busy_o        high while digits are being processed
//   done_o        one-cycle completion pulse
//   dbg_state_o   current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a request is taken on any rising edge where start_i=1 and the
// block is in IDLE or DONE (so back-to-back requests are accepted in the
// done cycle). start_i is ignored while busy_o=1. Operand inputs are only
// sampled on the accepting edge. The result is valid while done_o=1 and is
// held afterwards.
// ---------------------------------------------------------------------------
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [4*DIGITS-1:0] minuend_i,
  input  logic [4*DIGITS-1:0] subtrahend_i,
  input  logic                borrow_in_i,
  output logic [4*DIGITS-1:0] difference_o,
  output logic                borrow_out_o,
  output logic                invalid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          dbg_state_o
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             last_digit;
  logic             operand_bad;

  logic [W-1:0]     m_q, s_q, res_q, res_d;
  logic             b_q, b_d;
  logic             bad_q;
  logic [IDX_W-1:0] idx_q;
  logic [4:0]       diff_t;
  logic [3:0]       digit_d;

  logic [W-1:0]     difference_q;
  logic             borrow_out_q;
  logic             invalid_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CALC;
      ST_CALC: if (last_digit) state_d = ST_DONE;
      ST_DONE: state_d = start_i ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o      = (state_q == ST_CALC);
    done_o      = (state_q == ST_DONE);
    accept      = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    dbg_state_o = state_q;
  end

  assign last_digit = (idx_q == LAST_IDX);

  // Any non-BCD digit in either operand poisons the whole operation.
  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((minuend_i[4*i +: 4] > 4'd9) || (subtrahend_i[4*i +: 4] > 4'd9))
        operand_bad = 1'b1;
    end
  end

  // Single digit stage. The operands shift right so the current digit is
  // always in [3:0]; result digits enter at the top and after DIGITS shifts
  // digit k has arrived at bits [4k+3:4k].
  always_comb begin
    diff_t = {1'b0, m_q[3:0]} - {1'b0, s_q[3:0]} - {4'b0000, b_q};
    if (diff_t[4]) begin
      digit_d = diff_t[3:0] + 4'd10;
      b_d     = 1'b1;
    end else begin
      digit_d = diff_t[3:0];
      b_d     = 1'b0;
    end
    res_d = (res_q >> 4) | (W'(digit_d) << (W - 4));
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      m_q          <= '0;
      s_q          <= '0;
      b_q          <= 1'b0;
      bad_q        <= 1'b0;
      idx_q        <= '0;
      res_q        <= '0;
      difference_q <= '0;
      borrow_out_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else if (accept) begin
      m_q   <= minuend_i;
      s_q   <= subtrahend_i;
      b_q   <= borrow_in_i;
      bad_q <= operand_bad;
      idx_q <= '0;
      res_q <= '0;
    end else if (state_q == ST_CALC) begin
      m_q   <= m_q >> 4;
      s_q   <= s_q >> 4;
      b_q   <= b_d;
      res_q <= res_d;
      idx_q <= idx_q + IDX_W'(1);
      // Visible outputs change only on the edge that enters DONE.
      if (last_digit) begin
        difference_q <= bad_q ? '0 : res_d;
        borrow_out_q <= bad_q ? 1'b0 : b_d;
        invalid_q    <= bad_q;
      end
    end
  end

  assign difference_o = difference_q;
  assign borrow_out_o = borrow_out_q;
  assign invalid_o    = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] m_in  = '0;
  logic [W-1:0] s_in  = '0;
  logic         b_in  = 1'b0;
  logic [W-1:0] difference_o;
  logic         borrow_out_o, invalid_o, busy_o, done_o;
  logic [1:0]   dbg_state_o;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .minuend_i    (m_in),
    .subtrahend_i (s_in),
    .borrow_in_i  (b_in),
    .difference_o (difference_o),
    .borrow_out_o (borrow_out_o),
    .invalid_o    (invalid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .dbg_state_o  (dbg_state_o)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {invalid, borrow_out, difference}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] held_exp = '0;
  int           busy_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal integer arithmetic on the decoded operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] m, input logic [W-1:0] s,
                                         input logic b);
    int           mv = 0;
    int           sv = 0;
    int           p  = 1;
    int           r;
    bit           bad = 0;
    logic         bo  = 1'b0;
    logic [W-1:0] res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (m[4*i +: 4] > 4'd9 || s[4*i +: 4] > 4'd9) bad = 1;
      mv += int'(m[4*i +: 4]) * p;
      sv += int'(s[4*i +: 4]) * p;
      p  *= 10;
    end
    if (bad) return {1'b1, 1'b0, {W{1'b0}}};
    r = mv - sv - int'(b);
    if (r < 0) begin
      r += p;
      bo = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r /= 10;
    end
    return {1'b0, bo, res};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 31) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_exp = '0;
      busy_run = 0;
    end else if (done_o) begin
      chk("busy_cycles_before_done", 64'(busy_run), 64'(DIGITS));
      chk("busy_low_in_done", 64'(busy_o), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty queue, required no done");
      end else begin
        held_exp = exp_q.pop_front();
        chk("difference", 64'(difference_o), 64'(held_exp[W-1:0]));
        chk("borrow_out", 64'(borrow_out_o), 64'(held_exp[W]));
        chk("invalid",    64'(invalid_o),    64'(held_exp[W+1]));
      end
      busy_run = 0;
    end else if (busy_o) begin
      busy_run++;
      chk("outputs_held_in_calc", 64'({invalid_o, borrow_out_o, difference_o}), 64'(held_exp));
    end else begin
      busy_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge. Start stays high for 1+hold cycles while the
  // operand inputs are scrambled, which must not affect the latched operation.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] s, input logic b,
                       input int hold);
    m_in  = m;
    s_in  = s;
    b_in  = b;
    start = 1'b1;
    exp_q.push_back(model(m, s, b));
    @(negedge clk);
    chk("busy_after_start", 64'(busy_o), 64'd1);
    for (int i = 0; i < hold; i++) begin
      m_in = W'($urandom);
      s_in = W'($urandom);
      b_in = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    m_in  = W'($urandom);
    s_in  = W'($urandom);
    b_in  = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done_o; i++) @(negedge clk);
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 20 cycles, required done");
    end
  endtask

  task automatic run(input logic [W-1:0] m, input logic [W-1:0] s, input logic b,
                     input int hold, input int gap);
    issue(m, s, b, hold);
    wait_done();
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i == 0) chk("done_single_cycle", 64'(done_o), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    chk("reset_difference", 64'(difference_o), 64'd0);
    chk("reset_borrow_out", 64'(borrow_out_o), 64'd0);
    chk("reset_invalid",    64'(invalid_o),    64'd0);
    chk("reset_busy",       64'(busy_o),       64'd0);
    chk("reset_done",       64'(done_o),       64'd0);
    chk("reset_state",      64'(dbg_state_o),  64'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run(16'h5432, 16'h1234, 1'b0, 0, 1);
    run(16'h1000, 16'h0001, 1'b0, 0, 1);
    run(16'h0000, 16'h0001, 1'b0, 0, 1);
    run(16'h0500, 16'h0499, 1'b1, 0, 1);
    run(16'h12A4, 16'h0001, 1'b0, 0, 1);
    run(16'h0009, 16'h0003, 1'b0, 0, 1);
    run(16'h9999, 16'h0000, 1'b1, 0, 1);
    run(16'h0000, 16'h9999, 1'b1, 0, 1);

    // Start held through CALC, then back-to-back request in the done cycle
    run(16'h7315, 16'h2468, 1'b0, 3, 0);
    run(16'h0100, 16'h0001, 1'b0, 0, 2);

    // Asynchronous reset while digit 2 is being processed
    issue(16'h8765, 16'h4321, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_reset_difference", 64'(difference_o), 64'd0);
    chk("midop_reset_borrow_out", 64'(borrow_out_o), 64'd0);
    chk("midop_reset_invalid",    64'(invalid_o),    64'd0);
    chk("midop_reset_busy",       64'(busy_o),       64'd0);
    chk("midop_reset_done",       64'(done_o),       64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run(16'h0042, 16'h0042, 1'b0, 0, 1);

    // Randomized operations with random start hold and idle gaps
    for (int n = 0; n < 60; n++) begin
      run(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
